// File: rtl/ps2_rx_decoder.sv
// PS/2 device-to-host receiver: synchronizes and filters the raw lines, deframes
// 11-bit frames and strips set-2 E0/F0 prefixes to yield one strobed make code per key press.
module ps2_rx_decoder #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] ps2_code,
   output logic       code_valid,
   output logic       ps2_ext,
   output logic       frame_err
);

   localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
   localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   logic           clk_meta_q, clk_sync_q;
   logic           data_meta_q, data_sync_q;
   logic           filt_q, filt_d;
   logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
   logic           fall;

   state_t         state_q;
   logic [2:0]     bit_cnt_q;
   logic [7:0]     shift_q;
   logic           parity_q;
   logic [TCW-1:0] tmo_q;
   logic           brk_q, ext_q;
   logic [7:0]     code_q;
   logic           code_ext_q;
   logic           code_valid_q, frame_err_q;

   // Idle level of both PS/2 lines is high, so the synchronizers reset to 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_meta_q  <= 1'b1;
         clk_sync_q  <= 1'b1;
         data_meta_q <= 1'b1;
         data_sync_q <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments keep the two flops a true 2-stage chain.
         clk_meta_q  <= ps2_clk;
         clk_sync_q  <= clk_meta_q;
         data_meta_q <= ps2_data;
         data_sync_q <= data_meta_q;
      end
   end

   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
      filt_d     = filt_q;
      filt_cnt_d = '0;
      if (clk_sync_q != filt_q) begin
         if (filt_cnt_q == FCW'(FILTER_LEN - 1)) begin
            filt_d = clk_sync_q;
         end else begin
            filt_cnt_d = filt_cnt_q + FCW'(1);
         end
      end
   end

   assign fall = filt_q & ~filt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         filt_q     <= 1'b1;
         filt_cnt_q <= '0;
      end else begin
         filt_q     <= filt_d;
         filt_cnt_q <= filt_cnt_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         parity_q     <= 1'b0;
         tmo_q        <= '0;
         brk_q        <= 1'b0;
         ext_q        <= 1'b0;
         code_q       <= 8'hF0;
         code_ext_q   <= 1'b0;
         code_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         code_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;

         // A fall in the same cycle as the timeout wins and restarts the count.
         if (state_q == S_IDLE || fall) begin
            tmo_q <= '0;
         end else if (tmo_q == TCW'(TIMEOUT_CYCLES)) begin
            tmo_q       <= '0;
            state_q     <= S_IDLE;
            frame_err_q <= 1'b1;
         end else begin
            tmo_q <= tmo_q + TCW'(1);
         end

         if (fall) begin
            unique case (state_q)
               S_IDLE: begin
                  if (!data_sync_q) begin
                     state_q   <= S_DATA;
                     bit_cnt_q <= '0;
                  end
               end
               S_DATA: begin
                  shift_q   <= {data_sync_q, shift_q[7:1]};
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     state_q <= S_PARITY;
                  end
               end
               S_PARITY: begin
                  parity_q <= data_sync_q;
                  state_q  <= S_STOP;
               end
               S_STOP: begin
                  state_q <= S_IDLE;
                  if (data_sync_q && (^{shift_q, parity_q})) begin
                     if (shift_q == 8'hF0) begin
                        brk_q <= 1'b1;
                     end else if (shift_q == 8'hE0) begin
                        ext_q <= 1'b1;
                     end else if (brk_q) begin
                        brk_q <= 1'b0;
                        ext_q <= 1'b0;
                     end else begin
                        code_q       <= shift_q;
                        code_ext_q   <= ext_q;
                        code_valid_q <= 1'b1;
                        ext_q        <= 1'b0;
                     end
                  end else begin
                     frame_err_q <= 1'b1;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign ps2_code   = code_q;
   assign ps2_ext    = code_ext_q;
   assign code_valid = code_valid_q;
   assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_rx_decoder.sv
// Directed bench for ps2_rx_decoder: scaled-down PS/2 bit timing and timeout,
// hand-computed expected codes, strobe counts and strobe-exclusivity monitoring.
module tb_ps2_rx_decoder;

   localparam int FILTER_LEN     = 8;
   localparam int TIMEOUT_CYCLES = 400;
   localparam int HALF           = 40;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] ps2_code;
   logic       code_valid;
   logic       ps2_ext;
   logic       frame_err;

   int n_checks = 0;
   int n_pass   = 0;

   int cv_cnt = 0, fe_cnt = 0, both_cnt = 0, stray_cnt = 0;
   int cv_base, fe_base;
   logic [8:0] prev_out = 9'h0F0;

   always #5 clk = ~clk;

   ps2_rx_decoder #(
      .FILTER_LEN     (FILTER_LEN),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .ps2_code   (ps2_code),
      .code_valid (code_valid),
      .ps2_ext    (ps2_ext),
      .frame_err  (frame_err)
   );

   // Strobe counters and a watch for outputs changing without code_valid.
   always @(negedge clk) begin
      if (code_valid) cv_cnt++;
      if (frame_err) fe_cnt++;
      if (code_valid && frame_err) both_cnt++;
      if (!rst && ({ps2_ext, ps2_code} !== prev_out) && !code_valid) stray_cnt++;
      prev_out = {ps2_ext, ps2_code};
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic mark();
      cv_base = cv_cnt;
      fe_base = fe_cnt;
   endtask

   task automatic send_bit(input logic b);
      ps2_data = b;
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit((~^b) ^ bad_par);
      send_bit(1'b1);
      ps2_data = 1'b1;
      wait_cyc(2 * HALF);
   endtask

   task automatic send_partial(input logic [7:0] b);
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(b[i]);
      ps2_data = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      wait_cyc(5);
      check("rst_code", ps2_code, 8'hF0);
      check("rst_ext", ps2_ext, 0);
      check("rst_cv", code_valid, 0);
      check("rst_fe", frame_err, 0);
      rst = 1'b0;
      wait_cyc(20);

      // Single make code
      mark();
      send_frame(8'h1C, 1'b0);
      check("1c_cv", cv_cnt - cv_base, 1);
      check("1c_fe", fe_cnt - fe_base, 0);
      check("1c_code", ps2_code, 8'h1C);
      check("1c_ext", ps2_ext, 0);

      // Release of the same key: no output
      mark();
      send_frame(8'hF0, 1'b0);
      send_frame(8'h1C, 1'b0);
      check("rel_cv", cv_cnt - cv_base, 0);
      check("rel_code", ps2_code, 8'h1C);

      // Extended press then extended release
      mark();
      send_frame(8'hE0, 1'b0);
      send_frame(8'h75, 1'b0);
      check("e75_cv", cv_cnt - cv_base, 1);
      check("e75_code", ps2_code, 8'h75);
      check("e75_ext", ps2_ext, 1);
      mark();
      send_frame(8'hE0, 1'b0);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h75, 1'b0);
      check("e75rel_cv", cv_cnt - cv_base, 0);
      check("e75rel_code", ps2_code, 8'h75);
      check("e75rel_ext", ps2_ext, 1);
      mark();
      send_frame(8'h5A, 1'b0);
      check("5a_cv", cv_cnt - cv_base, 1);
      check("5a_code", ps2_code, 8'h5A);
      check("5a_ext", ps2_ext, 0);

      // Parity error then good retry
      mark();
      send_frame(8'h29, 1'b1);
      check("par_fe", fe_cnt - fe_base, 1);
      check("par_cv", cv_cnt - cv_base, 0);
      check("par_code", ps2_code, 8'h5A);
      mark();
      send_frame(8'h29, 1'b0);
      check("29_cv", cv_cnt - cv_base, 1);
      check("29_fe", fe_cnt - fe_base, 0);
      check("29_code", ps2_code, 8'h29);

      // Truncated frame followed by a long idle times out
      mark();
      send_partial(8'h5A);
      wait_cyc(3 * TIMEOUT_CYCLES);
      check("tmo_fe", fe_cnt - fe_base, 1);
      check("tmo_cv", cv_cnt - cv_base, 0);
      check("tmo_code", ps2_code, 8'h29);
      mark();
      send_frame(8'h5A, 1'b0);
      check("tmo5a_cv", cv_cnt - cv_base, 1);
      check("tmo5a_fe", fe_cnt - fe_base, 0);
      check("tmo5a_code", ps2_code, 8'h5A);

      // Short clock glitches with data low must not start a frame
      mark();
      for (int g = 0; g < 6; g++) begin
         ps2_data = 1'b0;
         ps2_clk = 1'b0;
         wait_cyc(3);
         ps2_clk = 1'b1;
         wait_cyc(20);
      end
      ps2_data = 1'b1;
      wait_cyc(3 * TIMEOUT_CYCLES);
      check("glitch_cv", cv_cnt - cv_base, 0);
      check("glitch_fe", fe_cnt - fe_base, 0);
      check("glitch_code", ps2_code, 8'h5A);

      // Reset in the middle of a frame
      mark();
      send_partial(8'h45);
      #2 rst = 1'b1;
      wait_cyc(3);
      check("mrst_code", ps2_code, 8'hF0);
      check("mrst_ext", ps2_ext, 0);
      check("mrst_cv", code_valid, 0);
      check("mrst_fe", frame_err, 0);
      ps2_clk = 1'b1;
      ps2_data = 1'b1;
      wait_cyc(5);
      rst = 1'b0;
      wait_cyc(2 * HALF);
      check("mrst_nostrobe", (cv_cnt - cv_base) + (fe_cnt - fe_base), 0);
      mark();
      send_frame(8'h16, 1'b0);
      check("16_cv", cv_cnt - cv_base, 1);
      check("16_fe", fe_cnt - fe_base, 0);
      check("16_code", ps2_code, 8'h16);
      check("16_ext", ps2_ext, 0);

      check("strobe_overlap", both_cnt, 0);
      check("stray_update", stray_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
